uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter (tx_start/tx_data in, tx_done out) between N on-chip requesters, such as the status reporter, the loopback echo and the debug dump.
- Arbitration is round-robin at packet granularity: a granted requester keeps the transmitter until it sends a byte flagged last.
- The block sits between the requesters and the UART TX in PE_FPGA_top and is the only driver of tx_start/tx_data.
- A watchdog releases the transmitter if tx_done never arrives or an owner stalls mid-packet.

---
 rtl/uart_arb_pkg.sv | 10 +
 rtl/rr_picker.sv | 20 ++
 rtl/uart_tx_arbiter.sv | 98 +++++++++
 tb/tb_uart_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared states, byte width and default watchdog limits for the UART TX arbiter
package uart_arb_pkg;
   typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_e;
   localparam int BYTE_W             = 8;
   localparam int DEF_TIMEOUT_CYCLES = 200000;
   localparam int DEF_HOLD_CYCLES    = 1024;
   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or above ptr, wrapping
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);
   function automatic logic [IW-1:0] wrap(input int v);
      return IW'(v % N);
   endfunction
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[wrap(int'(ptr) + i)]) idx = wrap(int'(ptr) + i);
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART TX, with tx_done and hold watchdogs
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [BYTE_W*N_REQ-1:0]  req_data,
   input  logic [N_REQ-1:0]         req_last,
   output logic [N_REQ-1:0]         ack,
   output logic                     tx_start,
   output logic [BYTE_W-1:0]        tx_data,
   input  logic                     tx_done,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy,
   output logic                     err_timeout,
   output logic                     err_hold
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(imax(TIMEOUT_CYCLES, HOLD_CYCLES)) + 1;
   state_e            state_q;
   logic [IW-1:0]     ptr_q, ptr_d, owner_q, sel_idx, pick_idx;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N_REQ-1:0]  ack_q;
   logic [BYTE_W-1:0] data_q;
   logic              pick_valid, go, last_q, start_q, err_t_q, err_h_q;
   rr_picker #(.N(N_REQ)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );
   // A new byte is launched from IDLE by the picker, or from HOLD only by the locked owner
   assign go      = (state_q == IDLE) ? pick_valid : (state_q == HOLD) && req[owner_q];
   assign sel_idx = (state_q == IDLE) ? pick_idx : owner_q;
   assign ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         ack_q   <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
         err_t_q <= 1'b0;
         err_h_q <= 1'b0;
      end else begin
         start_q <= go;
         ack_q   <= go ? N_REQ'(1) << sel_idx : '0;
         if (go) begin
            state_q <= START;
            owner_q <= sel_idx;
            data_q  <= req_data[sel_idx*BYTE_W +: BYTE_W];
            last_q  <= req_last[sel_idx];
         end else begin
            case (state_q)
               START: begin
                  state_q <= WAIT;
                  cnt_q   <= '0;
               end
               WAIT: begin
                  if (tx_done) begin
                     state_q <= last_q ? IDLE : HOLD;
                     ptr_q   <= last_q ? ptr_d : ptr_q;
                     cnt_q   <= '0;
                  end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                     state_q <= IDLE;
                     ptr_q   <= ptr_d;
                     err_t_q <= 1'b1;
                  end else cnt_q <= cnt_d;
               end
               HOLD: begin
                  if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                     state_q <= IDLE;
                     ptr_q   <= ptr_d;
                     err_h_q <= 1'b1;
                  end else cnt_q <= cnt_d;
               end
               default: ;
            endcase
         end
      end
   end
   assign ack         = ack_q;
   assign tx_start    = start_q;
   assign tx_data     = data_q;
   assign owner       = owner_q;
   assign busy        = (state_q != IDLE);
   assign err_timeout = err_t_q;
   assign err_hold    = err_h_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized requesters and UART model, scoreboard monitor checking grants, bytes and watchdogs
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int T = 50;
   localparam int H = 16;
   typedef struct packed {logic [6:0] gap; logic last; logic [7:0] data;} item_t;
   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req, req_last, ack, act_r;
   logic [8*N-1:0] req_data;
   logic           tx_start, busy, err_timeout, err_hold;
   logic           tx_done = 1'b0;
   logic [7:0]     tx_data;
   logic [1:0]     owner;
   logic           uart_en = 1'b1;
   int             force_d = 0;
   int             compared = 0;
   int             mismatched = 0;
   item_t          pkt_q [N][$];
   logic [8:0]     exp_q [N][$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T), .HOLD_CYCLES(H)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_data    (req_data),
      .req_last    (req_last),
      .ack         (ack),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .owner       (owner),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_hold    (err_hold)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int r, input int gap, input logic last, input logic [7:0] d);
      item_t it;
      it.gap  = 7'(gap);
      it.last = last;
      it.data = d;
      pkt_q[r].push_back(it);
   endtask

   function automatic logic all_idle();
      logic ok;
      ok = !busy && (req == '0) && (act_r == '0);
      for (int k = 0; k < N; k++) ok = ok && (pkt_q[k].size() == 0) && (exp_q[k].size() == 0);
      return ok;
   endfunction

   function automatic int first_req(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic drain();
      int n = 0;
      do begin @(negedge clk); n++; end while (!all_idle() && n < 30000);
      chk("drain", 32'(all_idle()), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_start();
      int n = 0;
      do begin @(negedge clk); n++; end while (!tx_start && n < 2000);
      chk("start_seen", 32'(tx_start), 1);
   endtask

   task automatic chk_reset_vals();
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err_timeout", 32'(err_timeout), 0);
      chk("rst_err_hold", 32'(err_hold), 0);
   endtask

   // Requesters: hold req/data/last stable until ack, honouring each item's pre-request gap
   for (genvar g = 0; g < N; g++) begin : gen_rq
      logic       rq = 1'b0;
      logic       lq = 1'b0;
      logic       act = 1'b0;
      logic [7:0] dq = 8'h00;
      assign req[g]           = rq;
      assign req_last[g]      = lq;
      assign req_data[8*g +: 8] = dq;
      assign act_r[g]         = act;
      initial begin : drv
         item_t it;
         int    n;
         forever begin
            @(posedge clk);
            #1;
            if (pkt_q[g].size() == 0) begin
               rq = 1'b0;
               continue;
            end
            act = 1'b1;
            it  = pkt_q[g].pop_front();
            if (it.gap != 0) begin
               rq = 1'b0;
               repeat (int'(it.gap)) @(posedge clk);
               #1;
            end
            rq = 1'b1;
            dq = it.data;
            lq = it.last;
            exp_q[g].push_back({it.last, it.data});
            n = 0;
            do begin @(negedge clk); n++; end while (!ack[g] && n < 3000);
            if (!ack[g]) chk("ack_wait", 32'(ack[g]), 1);
            act = 1'b0;
         end
      end
   end

   // UART TX model: one tx_done pulse a random number of cycles after each accepted start
   initial begin : uart
      int d;
      forever begin
         @(negedge clk);
         if (tx_start && uart_en && rst_n) begin
            d = (force_d != 0) ? force_d : int'($urandom_range(1, 30));
            repeat (d) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
         end
      end
   end

   // Monitor: reference model of packet-level round robin, lock and watchdog rules
   initial begin : mon
      int         phase, wcnt, hcnt, m_ptr, m_own, g, exp_g;
      logic       m_last, m_et, m_eh, chk_t, chk_h, exp_start;
      logic [7:0] m_data;
      logic [8:0] e;
      logic [N-1:0] prev_req;
      phase = 0; wcnt = 0; hcnt = 0; m_ptr = 0; m_own = 0;
      m_last = 0; m_et = 0; m_eh = 0; chk_t = 0; chk_h = 0; exp_start = 0;
      m_data = '0; prev_req = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            phase = 0; m_ptr = 0; m_own = 0; m_et = 0; m_eh = 0;
            chk_t = 0; chk_h = 0; exp_start = 0; prev_req = req;
            continue;
         end
         if (chk_t) begin
            m_et = 1; chk_t = 0;
            chk("timeout_flag", 32'(err_timeout), 1);
            chk("timeout_idle", 32'(busy), 0);
         end
         if (chk_h) begin
            m_eh = 1; chk_h = 0;
            chk("hold_flag", 32'(err_hold), 1);
            chk("hold_idle", 32'(busy), 0);
         end
         if (exp_start || tx_start) chk("start_timing", 32'(tx_start), 32'(exp_start));
         exp_start = 0;
         if (!tx_start && ack != '0) chk("stray_ack", 32'(ack), 0);
         if (tx_start) begin
            chk("ack_onehot", 32'($onehot(ack)), 1);
            g = 0;
            for (int k = 0; k < N; k++) if (ack[k]) g = k;
            exp_g = (phase == 2) ? m_own : first_req(prev_req, m_ptr);
            chk("grantee", 32'(g), 32'(exp_g));
            chk("owner", 32'(owner), 32'(g));
            chk("busy_start", 32'(busy), 1);
            chk("err_timeout", 32'(err_timeout), 32'(m_et));
            chk("err_hold", 32'(err_hold), 32'(m_eh));
            if (exp_q[g].size() == 0) chk("byte_queued", exp_q[g].size(), 1);
            else begin
               e = exp_q[g].pop_front();
               chk("tx_data", 32'(tx_data), 32'(e[7:0]));
               m_last = e[8];
               m_data = e[7:0];
            end
            m_own = g; phase = 1; wcnt = 0;
         end else if (phase == 1) begin
            if (tx_done) begin
               chk("tx_data_hold", 32'(tx_data), 32'(m_data));
               if (m_last) begin phase = 0; m_ptr = (m_own + 1) % N; end
               else begin phase = 2; hcnt = 0; end
            end else begin
               wcnt++;
               if (wcnt == T) begin chk_t = 1; phase = 0; m_ptr = (m_own + 1) % N; end
            end
         end else if (phase == 2) begin
            if (req[m_own]) exp_start = 1;
            else begin
               hcnt++;
               if (hcnt == H) begin chk_h = 1; phase = 0; m_ptr = (m_own + 1) % N; end
            end
         end else if (req != '0) exp_start = 1;
         prev_req = req;
      end
   end

   initial begin : main
      int len;
      repeat (3) @(negedge clk);
      chk_reset_vals();
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(2, 0, 1'b1, 8'hA5);
      drain();
      for (int k = 0; k < 2; k++) begin
         push(0, 0, 1'b1, 8'(8'h10 + 16 * k));
         push(1, 0, 1'b1, 8'(8'h11 + 16 * k));
         push(3, 0, 1'b1, 8'(8'h13 + 16 * k));
      end
      drain();
      push(0, 0, 1'b0, 8'h30);
      push(0, 0, 1'b0, 8'h31);
      push(0, 0, 1'b1, 8'h32);
      push(1, 0, 1'b1, 8'h40);
      drain();
      force_d = T;
      push(2, 0, 1'b1, 8'h5A);
      drain();
      force_d = 0;
      uart_en = 1'b0;
      push(1, 0, 1'b1, 8'h66);
      wait_start();
      @(posedge clk);
      #1 uart_en = 1'b1;
      push(2, 0, 1'b1, 8'h77);
      drain();
      push(0, 0, 1'b0, 8'h11);
      push(1, 0, 1'b1, 8'h22);
      drain();
      for (int p = 0; p < 40; p++) begin
         int r;
         r   = int'($urandom_range(0, N - 1));
         len = int'($urandom_range(1, 3));
         for (int b = 0; b < len; b++)
            push(r, (b == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 8)),
                 b == len - 1, 8'($urandom));
      end
      drain();
      uart_en = 1'b0;
      push(3, 0, 1'b1, 8'h5C);
      wait_start();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk_reset_vals();
      @(posedge clk);
      #1 rst_n = 1'b1;
      uart_en = 1'b1;
      push(0, 0, 1'b1, 8'hAA);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
